trace_collector: RTL and testbench

Simulation-and-FPGA trace sink at the back end of the `mips` pipeline. It captures architectural side effects the CPU emits (register-file writes from WB, data-memory writes from MEM), orders them, buffers them in a FIFO, and presents them one record at a time on a valid/ready stream to a checker or log dumper. It sits beside `mips` under the bench top and observes the CPU without influencing it.

---
 rtl/trace_pkg.sv | 18 +
 rtl/trace_fifo.sv | 59 +++++
 rtl/trace_collector.sv | 134 +++++++++++++
 tb/tb_trace_collector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: record kinds, record width and the packed trace record shared
// by the collector and its FIFO.
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  // kind + pc + addr + data
  localparam int REC_W = 97;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH-entry record store with a 2-wide write port and a single
// read port. Slot 1 is only written together with slot 0, and slot 0 always
// holds the older record, so ordering is fixed by the caller.
// The caller guarantees there is room for every record it writes.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en0_i,
  input  trace_rec_t                 wr_rec0_i,
  input  logic                       wr_en1_i,
  input  trace_rec_t                 wr_rec1_i,
  input  logic                       rd_en_i,
  output trace_rec_t                 rd_rec_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  trace_rec_t      mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   widx0, widx1;

  assign widx0    = wptr_q[AW-1:0];
  assign widx1    = widx0 + AW'(1);
  assign empty_o  = (wptr_q == rptr_q);
  assign occ_o    = wptr_q - rptr_q;
  assign rd_rec_o = mem_q[rptr_q[AW-1:0]];

  // Pointer advance: up to two writes and one read per cycle.
  always_comb begin
    wptr_d = wptr_q + PW'(wr_en0_i) + PW'(wr_en1_i);
    rptr_d = rptr_q + PW'(rd_en_i);
  end

  // Pointer registers; the extra MSB separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage writes; contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (wr_en0_i) mem_q[widx0] <= wr_rec0_i;
    if (wr_en1_i) mem_q[widx1] <= wr_rec1_i;
  end

endmodule

// File: rtl/trace_collector.sv
// trace_collector: captures GRF writes (WB) and DM stores (MEM) from the CPU,
// orders them GRF-first, buffers them and streams them out one record at a
// time. Records that do not fit are dropped whole and counted.
// Optional macro TRACE_DISPLAY_EN adds a simulation-only log of every push
// and drop; without it the block is plain synthesizable logic.
//
// Output handshake: a record transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and the out_*
// payload holds steady while out_valid=1 and out_ready=0.
module trace_collector
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grf_we,
  input  logic [31:0]      grf_pc,
  input  logic [4:0]       grf_addr,
  input  logic [31:0]      grf_wdata,
  input  logic             dm_we,
  input  logic [31:0]      dm_pc,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_kind,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] rec_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 2;

  trace_rec_t      grf_rec, dm_rec, wr_rec0, head_rec;
  logic            grf_v, dm_v, pop;
  logic            push_grf, push_dm, drop_grf, drop_dm;
  logic            wr_en0, wr_en1, fifo_empty;
  logic [AW:0]     occ;
  logic [FW-1:0]   free;
  logic [1:0]      n_push, n_drop;
  logic [CNT_W:0]  drop_sum;

  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] rec_cnt_q, rec_cnt_d;

  assign grf_rec = '{kind: KIND_GRF, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wdata};
  assign dm_rec  = '{kind: KIND_DM,  pc: dm_pc,  addr: dm_addr,           data: dm_wdata};

  // Event filtering and the drop decision. Free space counts the slot
  // released by a same-cycle pop; a record is either written whole or dropped.
  always_comb begin
    grf_v    = grf_we && (grf_addr != 5'd0);
    dm_v     = dm_we;
    pop      = out_valid && out_ready;
    free     = FW'(DEPTH) - FW'(occ) + FW'(pop);
    push_grf = grf_v && (free != '0);
    push_dm  = dm_v && (grf_v ? (free >= FW'(2)) : (free != '0));
    drop_grf = grf_v && !push_grf;
    drop_dm  = dm_v && !push_dm;
    n_push   = {1'b0, push_grf} + {1'b0, push_dm};
    n_drop   = {1'b0, drop_grf} + {1'b0, drop_dm};
    // Slot 0 always carries the older record.
    wr_en0   = push_grf || push_dm;
    wr_rec0  = push_grf ? grf_rec : dm_rec;
    wr_en1   = push_grf && push_dm;
  end

  // Counter and sticky-flag next state; drop count saturates at all-ones.
  always_comb begin
    rec_cnt_d  = rec_cnt_q + CNT_W'(n_push);
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    overflow_d = overflow_q || (n_drop != 2'd0);
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      rec_cnt_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      rec_cnt_q  <= rec_cnt_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en0_i  (wr_en0),
    .wr_rec0_i (wr_rec0),
    .wr_en1_i  (wr_en1),
    .wr_rec1_i (dm_rec),
    .rd_en_i   (pop),
    .rd_rec_o  (head_rec),
    .empty_o   (fifo_empty),
    .occ_o     (occ)
  );

  // Output stream; payload reads as zero whenever nothing is buffered.
  always_comb begin
    out_valid = !fifo_empty;
    out_kind  = out_valid ? head_rec.kind : 1'b0;
    out_pc    = out_valid ? head_rec.pc   : 32'd0;
    out_addr  = out_valid ? head_rec.addr : 32'd0;
    out_data  = out_valid ? head_rec.data : 32'd0;
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign rec_cnt  = rec_cnt_q;

`ifdef TRACE_DISPLAY_EN
  // Simulation log of pushes (in push order) and drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (push_grf) $display("@%08h: $%02d <= %08h", grf_pc, grf_addr, grf_wdata);
      if (drop_grf) $display("TRACE DROP @%08h", grf_pc);
      if (push_dm)  $display("@%08h: *%08h <= %08h", dm_pc, dm_addr, dm_wdata);
      if (drop_dm)  $display("TRACE DROP @%08h", dm_pc);
    end
  end
`endif

endmodule

// File: tb/tb_trace_collector.sv
// tb_trace_collector: directed stimulus with a record scoreboard. Drivers push
// the records they expect the DUT to accept; a monitor pops and compares each
// record the DUT hands over.
module tb_trace_collector;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             grf_we;
  logic [31:0]      grf_pc;
  logic [4:0]       grf_addr;
  logic [31:0]      grf_wdata;
  logic             dm_we;
  logic [31:0]      dm_pc;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic             out_valid;
  logic             out_ready;
  logic             out_kind;
  logic [31:0]      out_pc;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] rec_cnt;

  logic [96:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  trace_collector #(.DEPTH(16), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .grf_we    (grf_we),
    .grf_pc    (grf_pc),
    .grf_addr  (grf_addr),
    .grf_wdata (grf_wdata),
    .dm_we     (dm_we),
    .dm_pc     (dm_pc),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_pc    (out_pc),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .rec_cnt   (rec_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [96:0] act, input logic [96:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Return to the driving phase (just after a rising edge).
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One cycle of events; exp_g/exp_d say whether each record should be accepted.
  task automatic ev(input logic gw, input logic [31:0] gpc, input logic [4:0] ga,
                    input logic [31:0] gd, input logic exp_g,
                    input logic dw, input logic [31:0] dpc, input logic [31:0] da,
                    input logic [31:0] dd, input logic exp_d);
    grf_we = gw; grf_pc = gpc; grf_addr = ga; grf_wdata = gd;
    dm_we = dw;  dm_pc = dpc;  dm_addr = da;  dm_wdata = dd;
    if (exp_g) exp_q.push_back({1'b0, gpc, 27'd0, ga, gd});
    if (exp_d) exp_q.push_back({1'b1, dpc, da, dd});
    tick(1);
    grf_we = 1'b0;
    dm_we  = 1'b0;
  endtask

  task automatic chk_counters(input string tag, input int rec, input int drp, input logic ovf);
    chk({tag, "_rec_cnt"},  97'(rec_cnt),  97'(rec));
    chk({tag, "_drop_cnt"}, 97'(drop_cnt), 97'(drp));
    chk({tag, "_overflow"}, 97'(overflow), 97'(ovf));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got %h expected none",
                 {out_kind, out_pc, out_addr, out_data});
      end else begin
        chk("record", {out_kind, out_pc, out_addr, out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; out_ready = 1'b0;
    grf_we = 1'b0; grf_pc = '0; grf_addr = '0; grf_wdata = '0;
    dm_we = 1'b0; dm_pc = '0; dm_addr = '0; dm_wdata = '0;
    tick(2);

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 97'(out_valid), 97'(0));
    chk("rst_payload", {out_kind, out_pc, out_addr, out_data}, 97'(0));
    chk_counters("rst", 0, 0, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // Single GRF write, visible one edge later
    out_ready = 1'b1;
    ev(1'b1, 32'h3000, 5'd8, 32'h1234, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("latency_valid", 97'(out_valid), 97'(1));
    tick(1);
    chk("single_rec_cnt", 97'(rec_cnt), 97'(1));

    // Write to $0 is ignored and not counted
    ev(1'b1, 32'h3010, 5'd0, 32'hffff, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("zero_reg_valid", 97'(out_valid), 97'(0));
    chk("zero_reg_rec_cnt", 97'(rec_cnt), 97'(1));
    tick(1);

    // Dual event: GRF before DM
    ev(1'b1, 32'h3004, 5'd9, 32'h5, 1'b1, 1'b1, 32'h3008, 32'h10, 32'h7, 1'b1);
    tick(3);
    chk("dual_drained", 97'(exp_q.size()), 97'(0));
    chk("dual_rec_cnt", 97'(rec_cnt), 97'(3));

    // Fill with consumer stalled: 8 dual cycles fit, the 9th drops both
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ev(1'b1, 32'h3100 + 32'(8*i), 5'(i+1), 32'h100 + 32'(i), (i < 8),
         1'b1, 32'h3104 + 32'(8*i), 32'h200 + 32'(4*i), 32'h200 + 32'(i), (i < 8));
    end
    @(negedge clk);
    chk_counters("fill", 19, 2, 1'b1);
    chk("stall_hold0", {out_kind, out_pc, out_addr, out_data}, exp_q[0]);
    tick(1);
    @(negedge clk);
    chk("stall_hold1", {out_kind, out_pc, out_addr, out_data}, exp_q[0]);
    tick(1);

    // One pop leaves 15; dual event with a same-cycle pop fits both
    out_ready = 1'b1;
    tick(1);
    ev(1'b1, 32'h3200, 5'd20, 32'haaaa, 1'b1, 1'b1, 32'h3204, 32'h300, 32'hbbbb, 1'b1);
    // Full FIFO with a pop: only one slot, GRF goes in and DM is dropped
    ev(1'b1, 32'h3208, 5'd21, 32'hcccc, 1'b1, 1'b1, 32'h320c, 32'h304, 32'hdddd, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    chk_counters("full_pop", 22, 3, 1'b1);
    chk("full_pop_occupied", 97'(out_valid), 97'(1));
    tick(1);
    out_ready = 1'b1;
    tick(20);
    @(negedge clk);
    chk("drain_empty_q", 97'(exp_q.size()), 97'(0));
    chk("drain_valid", 97'(out_valid), 97'(0));
    tick(1);

    // Reset with 5 records buffered
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      ev(1'b1, 32'h3300 + 32'(4*i), 5'(i+3), 32'h50 + 32'(i), 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 97'(out_valid), 97'(0));
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 97'(out_valid), 97'(0));
    chk_counters("post_rst", 0, 0, 1'b0);
    tick(1);

    // Normal operation after reset
    out_ready = 1'b1;
    ev(1'b1, 32'h3400, 5'd31, 32'hdeadbeef, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick(3);
    chk("after_rst_drained", 97'(exp_q.size()), 97'(0));
    chk("after_rst_rec_cnt", 97'(rec_cnt), 97'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
